// File: rtl/control_booth_r4.sv
// Control sequencer for a radix-4 (modified) Booth signed multiplier.
// It drives the load/add/shift strobes of an external A/Q/M datapath and handshakes with the host.
module control_booth_r4 #(
  parameter int N_ITER = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] q_low,
  output logic       carga_a,
  output logic       carga_q,
  output logic       carga_m,
  output logic       desplaza_a,
  output logic       desplaza_q,
  output logic       sel_ini,
  output logic       resta,
  output logic       sel_m2,
  output logic       ready,
  output logic       done
);

  // The counter only has to reach N_ITER-1; keep it at least one bit wide.
  localparam int CW = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(N_ITER - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    EVAL   = 3'd2,
    SHIFT1 = 3'd3,
    SHIFT2 = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   iter_cnt;
  logic [CW-1:0]   iter_cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      iter_cnt <= '0;
    end else begin
      state    <= state_nxt;
      iter_cnt <= iter_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    iter_cnt_nxt = iter_cnt;
    carga_a      = 1'b0;
    carga_q      = 1'b0;
    carga_m      = 1'b0;
    desplaza_a   = 1'b0;
    desplaza_q   = 1'b0;
    sel_ini      = 1'b0;
    resta        = 1'b0;
    sel_m2       = 1'b0;
    ready        = 1'b0;
    done         = 1'b0;

    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = LOAD;
      end

      LOAD: begin
        carga_a      = 1'b1;
        carga_q      = 1'b1;
        carga_m      = 1'b1;
        sel_ini      = 1'b1;
        iter_cnt_nxt = '0;
        state_nxt    = EVAL;
      end

      // Booth window {Q1,Q0,Q-1} selects 0, +M, +2M, -2M or -M.
      EVAL: begin
        case (q_low)
          3'b001, 3'b010: begin
            carga_a = 1'b1;
          end
          3'b011: begin
            carga_a = 1'b1;
            sel_m2  = 1'b1;
          end
          3'b100: begin
            carga_a = 1'b1;
            resta   = 1'b1;
            sel_m2  = 1'b1;
          end
          3'b101, 3'b110: begin
            carga_a = 1'b1;
            resta   = 1'b1;
          end
          default: begin
            carga_a = 1'b0;
          end
        endcase
        state_nxt = SHIFT1;
      end

      SHIFT1: begin
        desplaza_a = 1'b1;
        desplaza_q = 1'b1;
        state_nxt  = SHIFT2;
      end

      SHIFT2: begin
        desplaza_a = 1'b1;
        desplaza_q = 1'b1;
        if (iter_cnt == LAST_ITER) begin
          state_nxt = DONE;
        end else begin
          iter_cnt_nxt = iter_cnt + CW'(1);
          state_nxt    = EVAL;
        end
      end

      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt    = IDLE;
        iter_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_control_booth_r4.sv
// Bench for control_booth_r4: cycle-phase reference model for the strobes,
// plus a behavioural A/Q/M datapath to check products end to end.
module tb_control_booth_r4;

  localparam int N = 2;
  localparam int LAT = 3 * N + 1;
  localparam int PERIOD_B2B = 3 * N + 3;
  localparam logic [9:0] IDLE_VEC = 10'b00_0000_0010;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] q_drv;
  logic [2:0] q_low;
  logic       carga_a, carga_q, carga_m, desplaza_a, desplaza_q;
  logic       sel_ini, resta, sel_m2, ready, done;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];

  // reference model state: busy flag and cycle index since start was sampled
  bit  m_busy;
  int  m_k;
  int  step_idx;
  int  start_step;
  int  last_done;
  int  done_cnt;
  bit  hold_test;

  // behavioural datapath
  bit         use_dp;
  logic [3:0] dp_mop, dp_qop;
  logic [5:0] dp_a, dp_m;
  logic [4:0] dp_q;

  control_booth_r4 #(.N_ITER(N)) dut (
    .clk(clk), .reset(reset), .start(start), .q_low(q_low),
    .carga_a(carga_a), .carga_q(carga_q), .carga_m(carga_m),
    .desplaza_a(desplaza_a), .desplaza_q(desplaza_q), .sel_ini(sel_ini),
    .resta(resta), .sel_m2(sel_m2), .ready(ready), .done(done)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign q_low = use_dp ? dp_q[2:0] : q_drv;

  always @(posedge clk) begin
    if (carga_a && sel_ini) begin
      dp_a <= 6'd0;
      if (carga_q) dp_q <= {dp_qop, 1'b0};
      if (carga_m) dp_m <= {{2{dp_mop[3]}}, dp_mop};
    end else if (carga_a) begin
      if (resta) dp_a <= dp_a - (sel_m2 ? {dp_m[4:0], 1'b0} : dp_m);
      else       dp_a <= dp_a + (sel_m2 ? {dp_m[4:0], 1'b0} : dp_m);
    end else if (desplaza_a && desplaza_q) begin
      dp_a <= {dp_a[5], dp_a[5:1]};
      dp_q <= {dp_a[0], dp_q[4:1]};
    end
  end

  function automatic logic [9:0] outs();
    return {carga_a, carga_q, carga_m, desplaza_a, desplaza_q,
            sel_ini, resta, sel_m2, ready, done};
  endfunction

  // Expected strobes from the position in the operation and the Booth digit value.
  function automatic logic [9:0] model_out(bit busy, int k, logic [2:0] q);
    int w;
    logic [9:0] v;
    v = 10'd0;
    if (!busy) return IDLE_VEC;
    if (k == 0) begin
      v[9] = 1'b1; v[8] = 1'b1; v[7] = 1'b1; v[4] = 1'b1;
    end else if (k == LAT) begin
      v[0] = 1'b1;
    end else if ((k - 1) % 3 == 0) begin
      w = int'(q[0]) + int'(q[1]) - 2 * int'(q[2]);
      v[9] = (w != 0);
      v[3] = (w < 0);
      v[2] = (w == 2) || (w == -2);
    end else begin
      v[6] = 1'b1; v[5] = 1'b1;
    end
    return v;
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (step %0d, t=%0t)", tag, obs, exp, step_idx, $time);
    end
  endtask

  // driver: called at a negedge, compares this cycle, advances through one posedge
  task automatic step(input logic s, input logic [2:0] q);
    logic [9:0] p;
    start = s;
    q_drv = q;
    #1;
    check_eq("ctl", 16'(outs()), 16'(model_out(m_busy, m_k, q_low)));
    if (done) begin
      check_eq("latency", 16'(step_idx - start_step - 1), 16'(LAT));
      if (hold_test && last_done >= 0)
        check_eq("b2b_period", 16'(step_idx - last_done), 16'(PERIOD_B2B));
      last_done = step_idx;
      done_cnt++;
      if (use_dp) begin
        p = {dp_a, dp_q[4:1]};
        if (exp_q.size() > 0) check_eq("product", 16'(p), 16'(exp_q.pop_front()));
        else check_eq("product_unexpected", 16'(p), 16'h0);
      end
    end
    @(posedge clk);
    if (!m_busy) begin
      if (s) begin
        m_busy = 1'b1;
        m_k = 0;
        start_step = step_idx;
      end
    end else begin
      m_k++;
      if (m_k > LAT) m_busy = 1'b0;
    end
    step_idx++;
    @(negedge clk);
  endtask

  task automatic run_mult(input logic [3:0] mop, input logic [3:0] qop);
    int prod;
    bit seen;
    dp_mop = mop;
    dp_qop = qop;
    prod = $signed(mop) * $signed(qop);
    exp_q.push_back(10'(prod));
    use_dp = 1'b1;
    step(1'b1, 3'b000);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      seen = done;
      step(1'b0, 3'b000);
    end
    if (!seen) check_eq("done_timeout", 16'd0, 16'd1);
    exp_q.delete();
    use_dp = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; q_drv = 3'b000; use_dp = 1'b0;
    dp_mop = 4'd0; dp_qop = 4'd0;
    m_busy = 1'b0; m_k = 0; step_idx = 0; start_step = 0;
    last_done = -1; done_cnt = 0; hold_test = 1'b0;
    #2;
    check_eq("reset_outputs", 16'(outs()), 16'(IDLE_VEC));
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step(1'b0, 3'b000);

    // basic sequence with +2M decode; a start pulse in SHIFT1 must be ignored
    step(1'b1, 3'b011);
    step(1'b0, 3'b011);
    step(1'b0, 3'b011);
    step(1'b1, 3'b011);
    for (int i = 0; i < 7; i++) step(1'b0, 3'b011);
    check_eq("seq_done_count", 16'(done_cnt), 16'd1);

    // every Booth code, held through a whole operation
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 3'(c));
      for (int i = 0; i < LAT + 2; i++) step(1'b0, 3'(c));
    end

    // start held high: back-to-back operations
    done_cnt = 0; last_done = -1; hold_test = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b1, 3'($urandom_range(0, 7)));
    check_eq("held_done_count", 16'(done_cnt), 16'd2);
    hold_test = 1'b0;
    for (int i = 0; i < LAT + 3; i++) step(1'b0, 3'b000);

    // abort in SHIFT1 of the first iteration
    done_cnt = 0;
    step(1'b1, 3'b010);
    step(1'b0, 3'b010);
    step(1'b0, 3'b010);
    reset = 1'b1;
    #1;
    check_eq("abort_outputs", 16'(outs()), 16'(IDLE_VEC));
    m_busy = 1'b0; m_k = 0;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_hold", 16'(outs()), 16'(IDLE_VEC));
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 3'b111);
    check_eq("abort_no_done", 16'(done_cnt), 16'd0);
    step(1'b1, 3'b101);
    for (int i = 0; i < LAT + 2; i++) step(1'b0, 3'b101);
    check_eq("post_abort_done", 16'(done_cnt), 16'd1);

    // random start/q_low traffic
    for (int i = 0; i < 200; i++)
      step(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)));
    for (int i = 0; i < LAT + 3; i++) step(1'b0, 3'b000);

    // end-to-end products through the behavioural datapath
    run_mult(4'b1101, 4'b0101);
    run_mult(4'b0111, 4'b1000);
    run_mult(4'b1000, 4'b1000);
    run_mult(4'b0111, 4'b0111);
    for (int i = 0; i < 24; i++)
      run_mult(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
